// File: rtl/if_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] IRQ_VECTOR       = 32'h8000_0004;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;
  localparam int unsigned SUPERVISOR_BIT   = 31;

  typedef enum logic [1:0] {
    ID_HOLD   = 2'd0,
    ID_LOAD   = 2'd1,
    ID_BUBBLE = 2'd2
  } id_ctrl_e;

  // Sequential increment keeps the supervisor bit; the low bits wrap on their own.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    pc_inc = {pc[SUPERVISOR_BIT], pc[SUPERVISOR_BIT-1:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold, bubble or load of {inst, pc_plus4, valid}.
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  id_ctrl_e    ctrl,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc_plus4,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // Next-value selection for the pipeline register.
  always_comb begin
    inst_d     = inst_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    case (ctrl)
      ID_LOAD: begin
        inst_d     = load_inst;
        pc_plus4_d = load_pc_plus4;
        valid_d    = 1'b1;
      end
      ID_BUBBLE: begin
        inst_d     = NOP_INST;
        pc_plus4_d = load_pc_plus4;
        valid_d    = 1'b0;
      end
      ID_HOLD: begin
        inst_d     = inst_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
      end
      default: begin
        inst_d     = inst_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
      end
    endcase
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q     <= NOP_INST;
      pc_plus4_q <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      inst_q     <= inst_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign id_inst     = inst_q;
  assign id_pc_plus4 = pc_plus4_q;
  assign id_valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// Optional interrupt entry is enabled by defining IF_IRQ_EN.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct
`ifdef IF_IRQ_EN
  ,
  input  logic        irq,
  output logic        irq_taken,
  output logic [31:0] irq_epc
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_plus4_s;
  id_ctrl_e    id_ctrl_s;
  logic        irq_take_s;

`ifdef IF_IRQ_EN
  logic        irq_taken_q, irq_taken_d;
  logic [31:0] irq_epc_q, irq_epc_d;

  // Interrupts are only accepted in user mode and yield to redirect and stall.
  assign irq_take_s = irq & ~pc_q[SUPERVISOR_BIT] & ~redirect_en & ~stall;
`else
  assign irq_take_s = 1'b0;
`endif

  // Next-PC priority: redirect, interrupt, stall, sequential.
  always_comb begin
    pc_d       = pc_q;
    id_ctrl_s  = ID_HOLD;
    id_plus4_s = pc_inc(pc_q);
    if (redirect_en) begin
      pc_d       = redirect_pc;
      id_ctrl_s  = ID_BUBBLE;
      id_plus4_s = pc_inc(redirect_pc);
    end else if (irq_take_s) begin
      pc_d       = IRQ_VECTOR;
      id_ctrl_s  = ID_BUBBLE;
      id_plus4_s = pc_inc(IRQ_VECTOR);
    end else if (stall) begin
      pc_d       = pc_q;
      id_ctrl_s  = ID_HOLD;
      id_plus4_s = pc_inc(pc_q);
    end else begin
      pc_d       = pc_inc(pc_q);
      id_ctrl_s  = ID_LOAD;
      id_plus4_s = pc_inc(pc_q);
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef IF_IRQ_EN
  // Exception PC captures the discarded instruction's address for re-execution.
  always_comb begin
    irq_taken_d = irq_take_s;
    if (irq_take_s) begin
      irq_epc_d = pc_q;
    end else begin
      irq_epc_d = irq_epc_q;
    end
  end

  // Interrupt status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_taken_q <= 1'b0;
      irq_epc_q   <= 32'h0000_0000;
    end else begin
      irq_taken_q <= irq_taken_d;
      irq_epc_q   <= irq_epc_d;
    end
  end

  assign irq_taken = irq_taken_q;
  assign irq_epc   = irq_epc_q;
`endif

  if_id_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .ctrl          (id_ctrl_s),
    .load_inst     (imem_rdata),
    .load_pc_plus4 (id_plus4_s),
    .id_inst       (id_inst),
    .id_pc_plus4   (id_pc_plus4),
    .id_valid      (id_valid)
  );

  assign imem_addr = pc_q;
  assign id_opcode = id_inst[31:26];
  assign id_funct  = id_inst[5:0];

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: PC value loaded on reset (kernel mode, PC[31]=1).
REQ-002 Parameter NOP_INST, default 32'h0000_0000: instruction word placed in IF/ID on a bubble.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  load-use hold from the hazard unit: freeze PC and IF/ID.
REQ-006 redirect_en  input  1  taken branch, jump, jr or jalr resolved downstream.
REQ-007 redirect_pc  input  32  target PC, valid when redirect_en=1.
REQ-008 imem_addr  output  32  current PC, driven combinationally to instruction memory.
REQ-009 imem_rdata  input  32  instruction at imem_addr, same cycle (combinational memory).
REQ-010 id_inst  output  32  IF/ID instruction register.
REQ-011 id_pc_plus4  output  32  IF/ID PC+4 register (jal/jalr link value).
REQ-012 id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-013 id_opcode / id_funct  output  6 / 6  id_inst[31:26] / id_inst[5:0], fed directly to the ID decoder.

Function
REQ-014 PC increment SHALL be {PC[31], PC[30:0]+31'd4}: the supervisor bit is preserved and the low 31 bits wrap modulo 2^31.
REQ-015 Next-PC priority SHALL be reset > redirect_en > stall > PC+4.
REQ-016 On redirect_en=1, regardless of stall, PC SHALL load redirect_pc and IF/ID SHALL load a bubble (NOP_INST, valid=0, id_pc_plus4 = redirect_pc+4 per REQ-014).
REQ-017 With stall=1 and redirect_en=0, PC and all IF/ID registers SHALL hold their values.
REQ-018 With stall=0 and redirect_en=0, PC SHALL load PC+4 and IF/ID SHALL load {imem_rdata, PC+4, valid=1}.
REQ-019 Latency SHALL be one cycle: an instruction fetched at cycle N appears on id_inst at cycle N+1.
REQ-020 redirect_pc[1:0] SHALL be passed through unmodified; alignment checking is not done in this block.

Reset
REQ-021 While reset=1: PC=RESET_PC, id_inst=NOP_INST, id_valid=0, id_pc_plus4=RESET_PC.
REQ-022 Reset asserted mid-stall or mid-redirect SHALL win; the first fetch after deassertion is from RESET_PC.

Configuration
REQ-023 Macro IF_IRQ_EN, when defined, SHALL add ports irq (input, 1, level), irq_taken (output, 1, registered pulse) and irq_epc (output, 32, registered).
REQ-024 With IF_IRQ_EN defined, the interrupt is taken when irq=1, PC[31]=0, redirect_en=0 and stall=0. Priority is then reset > redirect > irq > stall > PC+4.
REQ-025 When the interrupt is taken: PC loads 32'h8000_0004, IF/ID loads a bubble, irq_epc loads the current PC (the discarded instruction is re-executed on return), and irq_taken=1 for exactly one cycle.
REQ-026 With IF_IRQ_EN defined, an interrupt that is blocked by redirect or stall SHALL remain pending while irq is high.
REQ-027 Without IF_IRQ_EN, the irq ports SHALL not exist and behaviour SHALL be exactly REQ-014..REQ-022.
REQ-028 With IF_IRQ_EN defined, irq_taken and irq_epc reset to 0.

Structure
REQ-029 Shared package if_pkg SHALL hold IRQ_VECTOR (32'h8000_0004), the default RESET_PC, the default NOP_INST and the supervisor-bit index (31).
REQ-030 The IF/ID register (inst, pc_plus4, valid; hold/bubble/load controls) SHALL be the single sub-module if_id_reg. PC register and next-PC mux stay in if_stage.

Verification
REQ-031 Reset released, stall=0, memory returns 32'h2008_0005 at 8000_0000 -> cycle 1: id_inst=2008_0005, id_opcode=6'h08, id_pc_plus4=8000_0004, id_valid=1, imem_addr=8000_0004.
REQ-032 stall=1 for 3 cycles -> imem_addr, id_inst and id_valid unchanged for all 3 cycles; sequential fetch resumes on the cycle after stall drops.
REQ-033 redirect_en=1, stall=1, redirect_pc=0040_0010 -> next cycle imem_addr=0040_0010, id_valid=0, id_inst=0.
REQ-034 PC=7FFF_FFFC sequential -> next PC=0000_0000 (bit 31 stays 0). PC=FFFF_FFFC -> next PC=8000_0000.
REQ-035 IF_IRQ_EN defined, PC=0040_0020, irq=1 -> imem_addr=8000_0004, irq_epc=0040_0020, irq_taken high one cycle. With PC[31]=1 the same irq is ignored.
REQ-036 Reset asserted during a redirect cycle -> PC=8000_0000, id_valid=0 on the next cycle.
